// File: rtl/uart_program_loader.sv
// UART 8N1 program loader: hunts for a 0xA5 sync byte, writes DEPTH data bytes into the CPU RAM,
// verifies a mod-256 checksum and holds the CPU while a frame is in flight.
module uart_program_loader #(
  parameter int unsigned CLK_FREQ_HZ  = 27_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  input  logic                     enable,
  output logic                     wr_en,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [7:0]               wr_data,
  output logic                     busy,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned Cpb  = CLK_FREQ_HZ / BAUD;
  localparam int unsigned Half = Cpb / 2;
  localparam int unsigned Tmo  = TIMEOUT_BITS * Cpb;
  localparam int unsigned Aw   = $clog2(DEPTH);
  localparam int unsigned Cw   = $clog2(Cpb);
  localparam int unsigned Tw   = $clog2(Tmo);
  localparam logic [7:0]  SyncByte = 8'hA5;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_st_e;
  typedef enum logic [1:0] {StIdle, StWaitSync, StData, StCheck} st_e;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_st_e        rx_st_q, rx_st_d;
  logic [Cw-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          start_edge, byte_valid, frame_err;

  st_e           st_q, st_d;
  logic [Aw-1:0] idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [Tw-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic          wr_en_q, wr_en_d;
  logic [Aw-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;

  assign start_edge = rx_prev_q & ~rx_sync_q;

  // Bit receiver: mid-bit sampling, start bit re-checked at half a bit to reject glitches.
  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_st_q)
      RxIdle: begin
        if (start_edge) begin
          rx_st_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == Cw'(Half - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          rx_st_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == Cw'(Cpb - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) rx_st_d = RxStop;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == Cw'(Cpb - 1)) begin
          cnt_d      = '0;
          rx_st_d    = RxIdle;
          byte_valid = rx_sync_q;
          frame_err  = ~rx_sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_st_d = RxIdle;
    endcase
  end

  // Inter-byte timer only runs mid-frame while the receiver waits for a start bit.
  always_comb begin
    tmo_d = '0;
    if ((st_q == StData || st_q == StCheck) && rx_st_q == RxIdle && !start_edge) begin
      tmo_d = tmo_q + 1'b1;
    end
  end
  assign tmo_hit = (tmo_q == Tw'(Tmo - 1));

  always_comb begin
    st_d      = st_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (st_q)
      StIdle: begin
        if (enable) st_d = StWaitSync;
      end
      StWaitSync: begin
        if (!enable) begin
          st_d = StIdle;
        end else if (byte_valid && shift_q == SyncByte) begin
          st_d    = StData;
          idx_d   = '0;
          sum_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StData, StCheck: begin
        // Abort takes priority over a byte completing in the same cycle.
        if (!enable || frame_err || tmo_hit) begin
          st_d    = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          error_d = 1'b1;
        end else if (byte_valid) begin
          if (st_q == StData) begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = shift_q;
            sum_d     = sum_q + shift_q;
            idx_d     = idx_q + 1'b1;
            if (idx_q == Aw'(DEPTH - 1)) st_d = StCheck;
          end else begin
            if (shift_q == sum_q) done_d  = 1'b1;
            else                  error_d = 1'b1;
            busy_d = 1'b0;
            st_d   = StIdle;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= RxIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      st_q      <= StIdle;
      idx_q     <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_st_q   <= rx_st_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      st_q      <= st_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: directed frames plus random byte streams, checked against a
// byte-stream model of the framing protocol.
module tb_uart_program_loader;

  localparam int unsigned Cpb = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       enable = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, cpu_hold, done, error;

  int         n_vec = 0;
  int         n_mis = 0;
  int         hold_bad = 0;
  int         both_bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  bit          m_done, m_error;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD        (100_000),
    .DEPTH       (16),
    .TIMEOUT_BITS(40)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .enable  (enable),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  always @(negedge clk) begin
    if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});
    if (cpu_hold !== busy) hold_bad++;
    if (done === 1'b1 && error === 1'b1) both_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(Cpb);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (!stop_ok) drive_bit(1'b1);
  endtask

  task automatic tx_stream(input logic [7:0] s[$], input bit bad[$], input int max_gap);
    foreach (s[i]) begin
      send_byte(s[i], !bad[i]);
      idle(Cpb * $urandom_range(0, max_gap));
    end
  endtask

  // Protocol model over the byte stream; a frame left open at the end is assumed aborted
  // (timeout or disable), which the caller arranges.
  task automatic model_stream(input logic [7:0] s[$], input bit bad[$]);
    int phase = 0;
    int n = 0;
    int sum = 0;
    foreach (s[i]) begin
      if (phase == 0) begin
        if (!bad[i] && s[i] == 8'hA5) begin
          phase = 1; n = 0; sum = 0; m_done = 0; m_error = 0;
        end
      end else if (bad[i]) begin
        m_error = 1; phase = 0;
      end else if (phase == 1) begin
        exp_q.push_back({4'(n), s[i]});
        sum = (sum + s[i]) % 256;
        n++;
        if (n == 16) phase = 2;
      end else begin
        if (int'(s[i]) == sum) m_done = 1;
        else                   m_error = 1;
        phase = 0;
      end
    end
    if (phase != 0) m_error = 1;
  endtask

  task automatic compare(input string tag);
    check({tag, ".nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s.wr%0d", tag, i), got_q[i], exp_q[i]);
    end
    check({tag, ".done"}, done, m_done);
    check({tag, ".error"}, error, m_error);
    check({tag, ".busy"}, busy, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic good_frame(output logic [7:0] s[$], output bit bd[$]);
    s = {}; bd = {};
    s.push_back(8'hA5); bd.push_back(0);
    for (int i = 0; i < 16; i++) begin s.push_back(8'(i)); bd.push_back(0); end
    s.push_back(8'h78); bd.push_back(0);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] s2[$];
    bit         bd[$];
    bit         bd2[$];
    int         sum;

    #1 rst_n = 1'b0;
    #1;
    check("rst.outs", {wr_en, wr_addr, wr_data, busy, cpu_hold, done, error}, '0);
    idle(3);
    rst_n  = 1'b1;
    enable = 1'b1;
    idle(5);

    // Good frame, with busy observed between sync and checksum.
    good_frame(s, bd);
    s2 = {8'hA5}; bd2 = {0};
    tx_stream(s2, bd2, 0);
    idle(3);
    check("good.busy_mid", busy, 1);
    s2 = s[1:$]; bd2 = bd[1:$];
    tx_stream(s2, bd2, 0);
    model_stream(s, bd);
    idle(50);
    compare("good");

    // Bad checksum.
    s = {8'hA5}; bd = {0};
    for (int i = 0; i < 16; i++) begin s.push_back(8'h11); bd.push_back(0); end
    s.push_back(8'h00); bd.push_back(0);
    tx_stream(s, bd, 0);
    model_stream(s, bd);
    idle(50);
    compare("badsum");

    // Sync hunt.
    good_frame(s, bd);
    s.push_front(8'hFF); bd.push_front(0);
    s.push_front(8'h3C); bd.push_front(0);
    tx_stream(s, bd, 1);
    model_stream(s, bd);
    idle(50);
    compare("hunt");

    // Framing error on data byte 5; rest of the frame follows and must be ignored.
    good_frame(s, bd);
    bd[6] = 1;
    tx_stream(s, bd, 0);
    model_stream(s, bd);
    idle(450);
    compare("frame");

    // Timeout after 8 data bytes.
    s = {8'hA5}; bd = {0};
    for (int i = 0; i < 8; i++) begin s.push_back(8'($urandom)); bd.push_back(0); end
    tx_stream(s, bd, 0);
    idle(380);
    check("tmo.early_err", error, 0);
    check("tmo.early_busy", busy, 1);
    idle(40);
    model_stream(s, bd);
    compare("tmo");

    // Disable after data byte 3; bytes sent while disabled produce nothing.
    s = {8'hA5}; bd = {0};
    for (int i = 0; i < 4; i++) begin s.push_back(8'($urandom)); bd.push_back(0); end
    tx_stream(s, bd, 0);
    idle(20);
    enable = 1'b0;
    idle(3);
    check("dis.error", error, 1);
    check("dis.busy", busy, 0);
    send_byte(8'hA5, 1);
    send_byte(8'h42, 1);
    model_stream(s, bd);
    compare("dis");
    enable = 1'b1;
    idle(5);

    // Async reset during data byte 2, then a short glitch on the idle line.
    s = {8'hA5, 8'h5A, 8'hC3}; bd = {0, 0, 0};
    tx_stream(s, bd, 0);
    model_stream(s, bd);
    fork
      send_byte(8'h99, 1);
      begin
        idle(45);
        rst_n = 1'b0;
        #1;
        check("rst_mid.outs", {wr_en, wr_addr, wr_data, busy, cpu_hold, done, error}, '0);
      end
    join
    m_done = 0; m_error = 0;
    check("rst_mid.nwr_before", got_q.size(), exp_q.size());
    got_q.delete();
    exp_q.delete();
    idle(3);
    rst_n = 1'b1;
    idle(5);
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(200);
    compare("glitch");

    // Random streams: junk prefix, random data, random checksum validity, occasional bad stop.
    for (int k = 0; k < 8; k++) begin
      s = {}; bd = {};
      repeat ($urandom_range(0, 2)) begin s.push_back(8'($urandom)); bd.push_back(0); end
      s.push_back(8'hA5); bd.push_back(0);
      sum = 0;
      for (int i = 0; i < 16; i++) begin
        s.push_back(8'($urandom));
        bd.push_back(0);
        sum = sum + s[s.size()-1];
      end
      if ($urandom_range(0, 1) == 1) s.push_back(8'(sum));
      else                           s.push_back(8'(sum + 1 + $urandom_range(0, 254)));
      bd.push_back(0);
      if ($urandom_range(0, 3) == 0) bd[$urandom_range(0, s.size() - 1)] = 1;
      tx_stream(s, bd, 3);
      model_stream(s, bd);
      idle(450);
      compare($sformatf("rnd%0d", k));
    end

    check("hold_eq_busy", hold_bad, 0);
    check("done_error_excl", both_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
